// File: rtl/glb_pkg.sv
// Shared GLB types and constants for the iact/weight/psum streamers.
package glb_pkg;

    localparam int unsigned DEFAULT_DATA_BITWIDTH = 16;
    localparam int unsigned DEFAULT_ADDR_BITWIDTH = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // One FIFO slot: a GLB word plus its window position tags.
    typedef struct packed {
        logic [DEFAULT_DATA_BITWIDTH-1:0] data;
        logic                             row_last;
        logic                             last;
    } iact_entry_t;

endpackage

// File: rtl/glb_iact_streamer_fifo.sv
// Small synchronous skid FIFO; push and pop may coincide, including when full.
module iact_skid_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 18,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             push_en;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full || pop_en);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= CNT_W'(DEPTH));
            assert (!(push_i && full && !pop_i));
        end
    end

endmodule

// File: rtl/glb_iact_streamer.sv
// Walks a 2-D GLB address window, issues single-word reads and streams the
// returned iact words with row/window tags to the PE scratchpad.
module glb_iact_streamer
    import glb_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH = DEFAULT_DATA_BITWIDTH,
    parameter int unsigned ADDR_BITWIDTH = DEFAULT_ADDR_BITWIDTH,
    parameter int unsigned LEN_BITWIDTH  = 8,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITWIDTH-1:0] cfg_base_addr,
    input  logic [LEN_BITWIDTH-1:0]  cfg_row_len,
    input  logic [LEN_BITWIDTH-1:0]  cfg_num_rows,
    input  logic [ADDR_BITWIDTH-1:0] cfg_row_stride,
    output logic                     busy,
    output logic                     done,
    output logic                     glb_read_req,
    output logic [ADDR_BITWIDTH-1:0] glb_r_addr,
    input  logic [DATA_BITWIDTH-1:0] glb_r_data,
    output logic [DATA_BITWIDTH-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_row_last,
    output logic                     out_last
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 2);
    localparam int unsigned ENTRY_W = DATA_BITWIDTH + 2;

    typedef struct packed {
        logic [DATA_BITWIDTH-1:0] data;
        logic                     row_last;
        logic                     last;
    } entry_t;

    state_e                   state_q, state_d;
    logic [LEN_BITWIDTH-1:0]  row_len_q, row_len_d;
    logic [LEN_BITWIDTH-1:0]  num_rows_q, num_rows_d;
    logic [ADDR_BITWIDTH-1:0] stride_q, stride_d;
    logic [LEN_BITWIDTH-1:0]  col_q, col_d;
    logic [LEN_BITWIDTH-1:0]  row_q, row_d;
    logic [ADDR_BITWIDTH-1:0] row_base_q, row_base_d;
    logic                     inflight_q;
    logic                     tag_row_last_q;
    logic                     tag_last_q;

    logic                     cfg_zero;
    logic                     start_accept;
    logic                     is_row_last;
    logic                     is_last;
    logic [OCC_W-1:0]         occupancy;
    logic                     can_issue;
    logic                     pop;
    logic                     drained;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_empty;
    entry_t                   push_entry;
    entry_t                   head_entry;

    assign cfg_zero     = (cfg_row_len == '0) || (cfg_num_rows == '0);
    assign start_accept = (state_q == IDLE) && start && !cfg_zero;
    assign is_row_last  = (col_q == (row_len_q - LEN_BITWIDTH'(1)));
    assign is_last      = is_row_last && (row_q == (num_rows_q - LEN_BITWIDTH'(1)));
    assign occupancy    = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign can_issue    = (occupancy < OCC_W'(FIFO_DEPTH));
    assign pop          = !fifo_empty && out_ready;
    // Last word leaving this cycle counts as drained so done follows it directly.
    assign drained      = !inflight_q &&
                          ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
    assign glb_r_addr   = row_base_q + ADDR_BITWIDTH'(col_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = cfg_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (glb_read_req && is_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        glb_read_req = 1'b0;
        case (state_q)
            RUN: begin
                busy         = 1'b1;
                glb_read_req = can_issue;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Window counters: row_base accumulates the stride instead of multiplying.
    always_comb begin
        row_len_d  = row_len_q;
        num_rows_d = num_rows_q;
        stride_d   = stride_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        if (start_accept) begin
            row_len_d  = cfg_row_len;
            num_rows_d = cfg_num_rows;
            stride_d   = cfg_row_stride;
            col_d      = '0;
            row_d      = '0;
            row_base_d = cfg_base_addr;
        end else if (glb_read_req && !is_last) begin
            if (is_row_last) begin
                col_d      = '0;
                row_d      = row_q + LEN_BITWIDTH'(1);
                row_base_d = row_base_q + stride_q;
            end else begin
                col_d = col_q + LEN_BITWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_len_q      <= '0;
            num_rows_q     <= '0;
            stride_q       <= '0;
            col_q          <= '0;
            row_q          <= '0;
            row_base_q     <= '0;
            inflight_q     <= 1'b0;
            tag_row_last_q <= 1'b0;
            tag_last_q     <= 1'b0;
        end else begin
            row_len_q      <= row_len_d;
            num_rows_q     <= num_rows_d;
            stride_q       <= stride_d;
            col_q          <= col_d;
            row_q          <= row_d;
            row_base_q     <= row_base_d;
            inflight_q     <= glb_read_req;
            tag_row_last_q <= is_row_last;
            tag_last_q     <= is_last;
        end
    end

    // Tags ride one cycle behind the request to line up with the GLB data.
    always_comb begin
        push_entry          = '0;
        push_entry.data     = glb_r_data;
        push_entry.row_last = tag_row_last_q;
        push_entry.last     = tag_last_q;
    end

    iact_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign out_data     = head_entry.data;
    assign out_row_last = out_valid && head_entry.row_last;
    assign out_last     = out_valid && head_entry.last;

endmodule

// File: tb/tb_glb_iact_streamer.sv
// Scoreboard bench for glb_iact_streamer with a registered-read GLB model.
module tb_glb_iact_streamer;
    import glb_pkg::*;

    localparam int unsigned DW         = 16;
    localparam int unsigned AW         = 10;
    localparam int unsigned LW         = 8;
    localparam int unsigned FIFO_DEPTH = 2;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] cfg_base_addr;
    logic [LW-1:0] cfg_row_len;
    logic [LW-1:0] cfg_num_rows;
    logic [AW-1:0] cfg_row_stride;
    logic          busy;
    logic          done;
    logic          glb_read_req;
    logic [AW-1:0] glb_r_addr;
    logic [DW-1:0] glb_r_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_row_last;
    logic          out_last;

    logic [DW-1:0] mem [1 << AW];
    logic [AW-1:0] addr_q [$];
    iact_entry_t   exp_q [$];

    int vectors = 0;
    int errors  = 0;

    glb_iact_streamer #(
        .DATA_BITWIDTH (DW),
        .ADDR_BITWIDTH (AW),
        .LEN_BITWIDTH  (LW),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_row_len    (cfg_row_len),
        .cfg_num_rows   (cfg_num_rows),
        .cfg_row_stride (cfg_row_stride),
        .busy           (busy),
        .done           (done),
        .glb_read_req   (glb_read_req),
        .glb_r_addr     (glb_r_addr),
        .glb_r_data     (glb_r_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row_last   (out_row_last),
        .out_last       (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GLB: one-cycle registered read, junk when not requested.
    always_ff @(posedge clk) begin
        glb_r_data <= glb_read_req ? mem[glb_r_addr] : 16'hDEAD;
    end

    // Pulse start with a window config and push the expected reads and words.
    task automatic kick(input int base, input int len, input int rows, input int stride);
        logic [AW-1:0] a;
        iact_entry_t   e;
        @(posedge clk); #1;
        cfg_base_addr  = AW'(base);
        cfg_row_len    = LW'(len);
        cfg_num_rows   = LW'(rows);
        cfg_row_stride = AW'(stride);
        start          = 1'b1;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < len; c++) begin
                a          = AW'(base + r * stride + c);
                e.data     = mem[a];
                e.row_last = (c == len - 1);
                e.last     = (c == len - 1) && (r == rows - 1);
                addr_q.push_back(a);
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs the active window: scores reads and words, the issue rule, stall
    // stability and done timing. ready_mode 1 drives out_ready 1,0,0,1,...
    task automatic run_window(input string name, input int ready_mode, input int stop_after,
                              input int inject_at, input int budget, output int first_valid);
        int            acc       = 0;
        int            issued    = 0;
        int            last_acc  = -1;
        bit            finished  = 1'b0;
        bit            stall_prev = 1'b0;
        bit            injected  = 1'b0;
        bit            exp_req;
        logic [DW+1:0] held      = '0;
        logic [AW-1:0] ea;
        iact_entry_t   ee;
        first_valid = -1;
        for (int c = 0; c < budget && !finished; c++) begin
            @(negedge clk);
            exp_req = busy && (addr_q.size() > 0) && ((issued - acc) < int'(FIFO_DEPTH));
            vectors++;
            if (glb_read_req !== exp_req) begin
                errors++;
                $display("FAIL %s issue c%0d: got req=%b expected %b (outstanding=%0d)",
                         name, c, glb_read_req, exp_req, issued - acc);
            end
            if (glb_read_req) begin
                issued++;
                if (addr_q.size() > 0) begin
                    ea = addr_q.pop_front();
                    vectors++;
                    if (glb_r_addr !== ea) begin
                        errors++;
                        $display("FAIL %s addr: got %h expected %h", name, glb_r_addr, ea);
                    end
                end
            end
            if (stall_prev) begin
                vectors++;
                if (!out_valid || ({out_data, out_row_last, out_last} !== held)) begin
                    errors++;
                    $display("FAIL %s stall_hold c%0d: got v=%b %h expected v=1 %h",
                             name, c, out_valid, {out_data, out_row_last, out_last}, held);
                end
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_word: got %h expected none", name, out_data);
                end else begin
                    ee = exp_q.pop_front();
                    vectors++;
                    if ({out_data, out_row_last, out_last} !== {ee.data, ee.row_last, ee.last}) begin
                        errors++;
                        $display("FAIL %s word%0d: got %h rl=%b l=%b expected %h rl=%b l=%b",
                                 name, acc, out_data, out_row_last, out_last,
                                 ee.data, ee.row_last, ee.last);
                    end
                end
                acc++;
                last_acc = c;
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_data, out_row_last, out_last};
            if (done) begin
                vectors++;
                if ((c != last_acc + 1) || (exp_q.size() != 0) || busy) begin
                    errors++;
                    $display("FAIL %s done_timing: got c%0d left=%0d busy=%b expected c%0d left=0 busy=0",
                             name, c, exp_q.size(), busy, last_acc + 1);
                end
                finished = 1'b1;
            end
            if (stop_after >= 0 && acc == stop_after) finished = 1'b1;
            if (!finished) begin
                @(posedge clk); #1;
                out_ready = (ready_mode == 0) ? 1'b1 : (((c + 1) % 3) == 0);
                start     = 1'b0;
                if (inject_at >= 0 && acc == inject_at && !injected) begin
                    cfg_base_addr  = 10'h3A0;
                    cfg_row_len    = 8'd5;
                    cfg_num_rows   = 8'd3;
                    cfg_row_stride = 10'h001;
                    start          = 1'b1;
                    injected       = 1'b1;
                end
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: got no done within %0d cycles expected done", name, budget);
        end
        out_ready = 1'b1;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, done, glb_read_req, glb_r_addr, out_valid, out_row_last, out_last} !== '0) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b req=%b addr=%h v=%b rl=%b l=%b expected all 0",
                     busy, done, glb_read_req, glb_r_addr, out_valid, out_row_last, out_last);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, glb_read_req, out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000", {busy, done, glb_read_req, out_valid});
        end
    endtask

    task automatic test_basic();
        int fv;
        kick(32'h010, 3, 2, 8);
        run_window("basic", 0, -1, -1, 60, fv);
        vectors++;
        if (fv != 2) begin
            errors++;
            $display("FAIL basic_latency: got first valid at c%0d expected c2", fv);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got done=%b expected 0", done);
        end
    endtask

    task automatic test_wrap();
        int fv;
        kick(32'h3FE, 4, 1, 0);
        run_window("wrap", 0, -1, -1, 60, fv);
    endtask

    task automatic test_backpressure();
        int fv;
        out_ready = 1'b1;
        kick(32'h040, 4, 2, 32'h010);
        run_window("backpressure", 1, -1, -1, 120, fv);
    endtask

    task automatic test_zero_length();
        kick(32'h020, 0, 5, 4);
        vectors++;
        if ({done, busy, glb_read_req} !== 3'b100) begin
            errors++;
            $display("FAIL zero_len_pulse: got done=%b busy=%b req=%b expected 1 0 0",
                     done, busy, glb_read_req);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({done, busy, glb_read_req} !== 3'b000) begin
                errors++;
                $display("FAIL zero_len_after%0d: got done=%b busy=%b req=%b expected 0 0 0",
                         i, done, busy, glb_read_req);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int fv;
        kick(32'h200, 3, 2, 5);
        run_window("start_busy", 0, -1, 2, 60, fv);
    endtask

    task automatic test_reset_mid_stream();
        int fv;
        kick(32'h080, 4, 2, 32'h008);
        run_window("pre_reset", 0, 3, -1, 60, fv);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({out_valid, busy, done, glb_read_req} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: got v=%b busy=%b done=%b req=%b expected 0 0 0 0",
                     out_valid, busy, done, glb_read_req);
        end
        reset = 1'b0;
        addr_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL reset_quiet%0d: got v=%b busy=%b done=%b expected 0 0 0",
                         i, out_valid, busy, done);
            end
        end
        kick(32'h100, 3, 2, 32'h020);
        run_window("post_reset", 0, -1, -1, 60, fv);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i * 2654 + 16'h1357);
        end
        reset          = 1'b1;
        start          = 1'b0;
        cfg_base_addr  = '0;
        cfg_row_len    = '0;
        cfg_num_rows   = '0;
        cfg_row_stride = '0;
        out_ready      = 1'b1;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_stream();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
